// File: rtl/iot_event_encoder_if.sv
// Event-encoder bus bundle.
//   dev_status : per-device activity level (1 = active), sampled on clk
//   en         : 1 = grants allowed, 0 = hold (edges still captured)
//   change     : one-cycle pulse, one event issued
//   on_off     : direction of issued event (1 = connect, 0 = disconnect)
//   dev_id     : index of the device whose event is issued
//   busy       : 1 while any device has a pending event
// master drives the status side; slave is the encoder itself.
interface iot_event_encoder_if #(
   parameter int unsigned N_DEV = 8,
   parameter int unsigned ID_W  = 3
);
   logic [N_DEV-1:0] dev_status;
   logic             en;
   logic             change;
   logic             on_off;
   logic [ID_W-1:0]  dev_id;
   logic             busy;

   modport master (
      output dev_status, en,
      input  change, on_off, dev_id, busy
   );

   modport slave (
      input  dev_status, en,
      output change, on_off, dev_id, busy
   );
endinterface

// File: rtl/iot_event_encoder.sv
// Device connect/disconnect event encoder.
// Detects edges on N_DEV status levels, keeps at most one net pending event
// per device and issues them one per cycle through a round-robin arbiter.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : iot_event_encoder_if.slave (dev_status, en in; change, on_off,
//         dev_id, busy out)
module iot_event_encoder #(
   parameter int unsigned N_DEV = 8,
   parameter int unsigned ID_W  = 3
) (
   input  logic               clk,
   input  logic               rst,
   iot_event_encoder_if.slave bus
);

   logic [N_DEV-1:0] status_q;
   logic [N_DEV-1:0] pend;
   logic [N_DEV-1:0] pend_dir;
   logic [N_DEV-1:0] pend_nxt;
   logic [N_DEV-1:0] dir_nxt;
   logic [N_DEV-1:0] edge_det;
   logic [N_DEV-1:0] grant;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  rr_ptr_nxt;
   logic [ID_W-1:0]  g_idx;
   logic             any_grant;
   int unsigned      idx;

   assign edge_det = bus.dev_status ^ status_q;

   // Round-robin search upward from rr_ptr, wrapping at N_DEV-1.
   always_comb begin
      any_grant = 1'b0;
      g_idx     = '0;
      idx       = 0;
      if (bus.en) begin
         for (int unsigned k = 0; k < N_DEV; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_DEV) idx = idx - N_DEV;
            if (!any_grant && pend[ID_W'(idx)]) begin
               any_grant = 1'b1;
               g_idx     = ID_W'(idx);
            end
         end
      end
      grant = any_grant ? (N_DEV'(1) << g_idx) : '0;
   end

   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (any_grant)
         rr_ptr_nxt = (g_idx == ID_W'(N_DEV - 1)) ? '0 : g_idx + ID_W'(1);
   end

   // Grant consumes the pending event first; an edge then either cancels a
   // still-pending event (net zero) or opens a new one in its direction.
   always_comb begin
      pend_nxt = pend;
      dir_nxt  = pend_dir;
      for (int unsigned i = 0; i < N_DEV; i++) begin
         pend_nxt[i] = pend[i] & ~grant[i];
         if (edge_det[i]) begin
            if (pend_nxt[i]) begin
               pend_nxt[i] = 1'b0;
            end else begin
               pend_nxt[i] = 1'b1;
               dir_nxt[i]  = bus.dev_status[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_q   <= '0;
         pend       <= '0;
         pend_dir   <= '0;
         rr_ptr     <= '0;
         bus.change <= 1'b0;
         bus.on_off <= 1'b0;
         bus.dev_id <= '0;
      end else begin
         status_q   <= bus.dev_status;
         pend       <= pend_nxt;
         pend_dir   <= dir_nxt;
         rr_ptr     <= rr_ptr_nxt;
         bus.change <= any_grant;
         if (any_grant) begin
            bus.on_off <= pend_dir[g_idx];
            bus.dev_id <= g_idx;
         end
      end
   end

   assign bus.busy = |pend;

endmodule

// File: tb/tb_iot_event_encoder.sv
module tb_iot_event_encoder;

   localparam int unsigned N = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   iot_event_encoder_if #(.N_DEV(N), .ID_W(3)) bus ();

   iot_event_encoder #(.N_DEV(N), .ID_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: per-device last status, pending flag and direction,
   // plus the round-robin pointer and the expected registered outputs.
   bit m_sq   [N];
   bit m_pend [N];
   bit m_dir  [N];
   int m_ptr;
   bit m_change;
   bit m_onoff;
   int m_id;
   int cnt;   // downstream counter fed by observed change pulses

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_sq[i] = 0; m_pend[i] = 0; m_dir[i] = 0;
      end
      m_ptr = 0; m_change = 0; m_onoff = 0; m_id = 0; cnt = 0;
   endtask

   task automatic model_step();
      int g;
      g = -1;
      if (bus.en) begin
         for (int k = 0; k < N; k++) begin
            int d;
            d = (m_ptr + k) % N;
            if (g < 0 && m_pend[d]) g = d;
         end
      end
      if (g >= 0) begin
         m_change = 1; m_onoff = m_dir[g]; m_id = g;
         m_pend[g] = 0; m_ptr = (g + 1) % N;
      end else begin
         m_change = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (bus.dev_status[i] != m_sq[i]) begin
            if (m_pend[i]) m_pend[i] = 0;
            else begin m_pend[i] = 1; m_dir[i] = bus.dev_status[i]; end
         end
         m_sq[i] = bus.dev_status[i];
      end
   endtask

   task automatic compare_all();
      int pc, net;
      bit any;
      pc = 0; net = 0; any = 0;
      for (int i = 0; i < N; i++) begin
         pc += m_sq[i];
         if (m_pend[i]) begin
            any = 1;
            net += m_dir[i] ? 1 : -1;
         end
      end
      chk("change", bus.change, m_change);
      chk("on_off", bus.on_off, m_onoff);
      chk("dev_id", bus.dev_id, m_id);
      chk("busy",   bus.busy,   any);
      if (bus.change) cnt += bus.on_off ? 1 : -1;
      chk("invariant", cnt & 255, (pc - net) & 255);
   endtask

   task automatic edge_step();
      @(posedge clk);
      if (!rst) model_reset();
      else model_step();
      #1;
      compare_all();
   endtask

   task automatic tick(input logic [N-1:0] st, input logic e);
      @(negedge clk);
      bus.dev_status = st;
      bus.en = e;
      edge_step();
   endtask

   // Async reset pulled between edges, held a couple of cycles, released at negedge.
   task automatic async_reset(input logic [N-1:0] st);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("rst_change", bus.change, 0);
      chk("rst_busy",   bus.busy,   0);
      chk("rst_dev_id", bus.dev_id, 0);
      tick(st, 1'b1);
      tick(st, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      edge_step();
   endtask

   logic [N-1:0] st;

   initial begin
      bus.dev_status = '0;
      bus.en = 1'b0;
      model_reset();
      #1;
      chk("reset_change", bus.change, 0);
      chk("reset_busy",   bus.busy,   0);
      tick('0, 1'b1);
      tick('0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      edge_step();

      // 1: single connect on device 3, two-clock latency
      tick(8'h08, 1'b1);
      chk("t1_busy", bus.busy, 1);
      chk("t1_nochg", bus.change, 0);
      tick(8'h08, 1'b1);
      chk("t1_change", bus.change, 1);
      chk("t1_id", bus.dev_id, 3);
      chk("t1_dir", bus.on_off, 1);
      tick(8'h08, 1'b1);
      chk("t1_pulse", bus.change, 0);

      // 2: all devices connect at once from rr_ptr = 0
      async_reset('0);
      tick(8'hFF, 1'b1);
      for (int i = 0; i < N; i++) begin
         tick(8'hFF, 1'b1);
         chk("t2_change", bus.change, 1);
         chk("t2_id", bus.dev_id, i);
         chk("t2_dir", bus.on_off, 1);
      end
      chk("t2_busy", bus.busy, 0);

      // 3: full vector pending with rr_ptr = 5
      for (int i = 0; i < 10; i++) tick(8'h00, 1'b1);
      for (int i = 0; i < 3; i++) tick(8'h10, 1'b1);
      tick(8'hEF, 1'b1);
      for (int i = 0; i < N; i++) begin
         tick(8'hEF, 1'b1);
         chk("t3_id", bus.dev_id, (5 + i) % N);
      end

      // 4: on then off before service cancels out
      for (int i = 0; i < 10; i++) tick(8'h00, 1'b1);
      tick(8'h04, 1'b0);
      tick(8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(8'h00, 1'b1);
         chk("t4_change", bus.change, 0);
         chk("t4_busy", bus.busy, 0);
      end

      // 5: grant and opposite edge on device 1 in the same cycle
      tick(8'h02, 1'b1);
      tick(8'h00, 1'b1);
      chk("t5_on_chg", bus.change, 1);
      chk("t5_on_id", bus.dev_id, 1);
      chk("t5_on_dir", bus.on_off, 1);
      tick(8'h00, 1'b1);
      chk("t5_off_chg", bus.change, 1);
      chk("t5_off_id", bus.dev_id, 1);
      chk("t5_off_dir", bus.on_off, 0);
      tick(8'h00, 1'b1);

      // 6: reset mid-drain, connects reissued for 4..7
      tick(8'hF0, 1'b0);
      tick(8'hF0, 1'b1);
      tick(8'hF0, 1'b1);
      async_reset(8'hF0);
      for (int i = 0; i < 4; i++) begin
         tick(8'hF0, 1'b1);
         chk("t6_id", bus.dev_id, 4 + i);
         chk("t6_dir", bus.on_off, 1);
      end

      // Random traffic against the model
      st = 8'hF0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) st = st ^ (8'($urandom) & 8'($urandom));
         if ($urandom_range(0, 199) == 0) async_reset(st);
         else tick(st, ($urandom_range(0, 4) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iot_event_encoder.md
Name: iot_event_encoder

Overview:
- Upstream neighbour of the active-device counter.
- Watches N_DEV per-device status levels (1 = device active) and detects connect/disconnect edges.
- Holds at most one net pending event per device and serialises events through a round-robin arbiter.
- Emits at most one event per cycle as change/on_off pulses, which drive the counter's change and on_off inputs directly.

Parameters:
N_DEV, 8, number of monitored devices (2..32)
ID_W, 3, width of dev_id; must satisfy 2**ID_W >= N_DEV

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
dev_status  input  N_DEV  per-device activity level, synchronous to clk
en  input  1  1 = grants allowed; 0 = hold (edges still captured)
change  output  1  one-cycle pulse, one event issued
on_off  output  1  direction of issued event: 1 = connect (count up), 0 = disconnect (count down)
dev_id  output  ID_W  index of device whose event is issued
busy  output  1  1 when any device has a pending event

Behaviour:
- Reset (rst=0, asynchronous):
  - status_q, pend, pend_dir, change, on_off, dev_id all 0.
  - rr_ptr = 0.
  - Deassertion is taken at the next clk edge.
  - Devices already high at release therefore generate connect events.
- Edge detect:
  - edge[i] = dev_status[i] ^ status_q[i].
  - status_q <= dev_status every cycle.
- Pending update, per device i, evaluated every clock:
  - Grant consumes the current pending event first: if grant[i], pend[i] is cleared.
  - Then, if edge[i]:
    - If pend[i] is still set (not granted this cycle), the edge cancels it: pend[i] <= 0. An on followed by an off before service is a net-zero event and is never issued.
    - Otherwise pend[i] <= 1 and pend_dir[i] <= dev_status[i].
  - Grant and edge on the same device in the same cycle: the granted event issues and the new opposite-direction edge becomes pending.
- Arbiter:
  - Combinational from pend, en and rr_ptr.
  - If en=1 and any pend set, grant the first set pend searching upward from rr_ptr, wrapping at N_DEV-1 -> 0.
  - Exactly one grant per cycle maximum.
  - On grant g: rr_ptr <= (g+1) mod N_DEV. With no grant, rr_ptr holds.
- Outputs:
  - Registered: change <= |grant; on_off <= pend_dir[g]; dev_id <= g.
  - When no grant: change <= 0, and on_off and dev_id hold their last values.
  - busy = |pend (combinational from registers).
- Latency:
  - dev_status toggle before edge E0 -> pend set at E0 -> change high after E1, for exactly one cycle.
  - Minimum latency is 2 clocks when idle.
- Invariant: with the counter reset together, counter value == popcount(status_q) - sum over i of (pend[i] ? (pend_dir[i] ? 1 : -1) : 0), mod 256.
- en=0: change forced 0 from the next edge; pends accumulate and cancel as normal; rr_ptr holds.
- Reset mid-operation: all pending events are discarded immediately, with no flush.
- Throughput:
  - 1 event/cycle.
  - A fully pending vector drains in N_DEV cycles.
  - A device can never hold more than one pending event, so no overflow condition exists.

Test Plan:
1. Reset release with dev_status=8'h00, then set bit 3 -> after 2 clocks change=1, on_off=1, dev_id=3 for one cycle; busy 1 for one cycle before that.
2. Set dev_status 8'h00->8'hFF in one cycle, en=1 -> eight consecutive change pulses with on_off=1 and dev_id 0,1,...,7; busy falls after the last grant.
3. Round robin: 8'hFF pending with rr_ptr=5 (after granting 4) -> issue order 5,6,7,0,1,2,3,4.
4. Cancellation: en=0; set bit 2 high, next cycle low; then en=1 -> no change pulse for device 2; busy=0.
5. Grant collision: device 1 pending on and granted in the same cycle it drops -> on event issued for id 1, then off event for id 1 one cycle later.
6. Async reset mid-drain: 8'hF0 pending, pull rst low between clock edges -> change, busy, dev_id go 0 immediately. On release with dev_status still 8'hF0, four connect events are reissued for ids 4..7.
- Every scenario also checks the monitor-counter invariant using a reference model.
